// File: rtl/ped_request_unit.sv
// Pedestrian push-button front end: synchronise, debounce, latch a crossing request,
// hold it to the signal controller with a level REQ / pulse ACK handshake, blink WAIT.
module ped_request_unit #(
  parameter int CLK_FREQ      = 12000000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LOCKOUT_MS    = 3000,
  parameter int BLINK_HALF_MS = 250
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  input  logic ACK,
  output logic REQ,
  output logic WAIT_LED,
  output logic BTN_CLEAN,
  output logic PRESS
);

  // Handshake: REQ is a level held from PRESS until ACK; ACK is a one-cycle pulse
  // that only has an effect while REQ is high (state PENDING).

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] LOCKOUT = 2'd2;

  localparam logic [31:0] TICK_MAX  = 32'(CLK_FREQ / 1000 - 1);
  localparam logic [31:0] DB_LIM    = 32'(DEBOUNCE_MS);
  localparam logic [31:0] LOCK_LIM  = 32'(LOCKOUT_MS);
  localparam logic [31:0] BLINK_LIM = 32'(BLINK_HALF_MS);

  logic [31:0] presc;
  logic        tick;
  logic        s1;
  logic        bs;
  logic [31:0] db_cnt;
  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [31:0] lock_cnt;
  logic [31:0] lock_nx;
  logic        defer;
  logic        defer_nx;
  logic [31:0] blink_cnt;

  assign tick = (presc == TICK_MAX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= 32'd0;
    end else if (tick) begin
      presc <= 32'd0;
    end else begin
      presc <= presc + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= 1'b0;
      bs <= 1'b0;
    end else begin
      s1 <= BTN;
      bs <= s1;
    end
  end

  // PRESS is registered alongside BTN_CLEAN so both rise in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      db_cnt    <= 32'd0;
      BTN_CLEAN <= 1'b0;
      PRESS     <= 1'b0;
    end else begin
      PRESS <= 1'b0;
      if (bs == BTN_CLEAN) begin
        db_cnt <= 32'd0;
      end else if (db_cnt >= DB_LIM) begin
        BTN_CLEAN <= bs;
        PRESS     <= bs;
        db_cnt    <= 32'd0;
      end else if (tick) begin
        db_cnt <= db_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    lock_nx  = lock_cnt;
    defer_nx = defer;
    case (state)
      IDLE: begin
        if (PRESS) state_nx = PENDING;
      end
      PENDING: begin
        if (ACK) begin
          state_nx = LOCKOUT;
          lock_nx  = 32'd0;
          defer_nx = 1'b0;
        end
      end
      LOCKOUT: begin
        if (lock_cnt >= LOCK_LIM) begin
          state_nx = (defer || PRESS) ? PENDING : IDLE;
          lock_nx  = 32'd0;
          defer_nx = 1'b0;
        end else begin
          if (tick)  lock_nx  = lock_cnt + 32'd1;
          if (PRESS) defer_nx = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        lock_nx  = 32'd0;
        defer_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      lock_cnt <= 32'd0;
      defer    <= 1'b0;
    end else begin
      state    <= state_nx;
      lock_cnt <= lock_nx;
      defer    <= defer_nx;
    end
  end

  // Outputs follow the next state so REQ/WAIT_LED change one cycle after PRESS/ACK.
  always_ff @(posedge CLK) begin
    if (RST) begin
      REQ <= 1'b0;
    end else begin
      REQ <= (state_nx == PENDING);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      WAIT_LED  <= 1'b0;
      blink_cnt <= 32'd0;
    end else if (state_nx != PENDING) begin
      WAIT_LED  <= 1'b0;
      blink_cnt <= 32'd0;
    end else if (state != PENDING) begin
      WAIT_LED  <= 1'b1;
      blink_cnt <= 32'd0;
    end else if (blink_cnt >= BLINK_LIM) begin
      WAIT_LED  <= ~WAIT_LED;
      blink_cnt <= 32'd0;
    end else if (tick) begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end

endmodule

// File: doc/ped_request_unit.md
Name: ped_request_unit

Overview:
- Pedestrian push-button front end that sits directly upstream of the traffic signal controller.
- Synchronises and debounces the raw crossing button, then latches a pedestrian request.
- Holds the request to the controller with a level REQ / pulse ACK handshake and drives a blinking "WAIT" indicator while the request is pending.
- Enforces a lockout interval after each grant, so one button press cannot re-trigger a crossing immediately.

Parameters:
- CLK_FREQ, 12000000: CLK frequency in Hz; one ms tick every CLK_FREQ/1000 cycles.
- DEBOUNCE_MS, 20: the button must be stable for this many ms before BTN_CLEAN follows it.
- LOCKOUT_MS, 3000: ms after ACK during which no new request is raised.
- BLINK_HALF_MS, 250: WAIT_LED half-period in ms.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; synchronous, active-high.
- BTN  in  1  raw button, asynchronous, active-high, may bounce.
- ACK  in  1  one-cycle grant pulse from the signal controller when the pedestrian phase starts.
- REQ  out  1  registered pedestrian request level to the controller.
- WAIT_LED  out  1  active-high blinking indicator while the request is pending.
- BTN_CLEAN  out  1  registered debounced button level.
- PRESS  out  1  one-cycle pulse on each debounced 0->1 edge.

Behaviour:
- Reset: all registers are cleared; sync FFs, prescaler, debounce counter, lockout counter, blink counter, deferred flag all go to 0; state = IDLE. REQ, WAIT_LED, BTN_CLEAN and PRESS are all 0 in the cycle after RST is sampled high. RST has priority over every other input.
- ms tick: 32-bit prescaler counts 0..CLK_FREQ/1000-1 and wraps to 0. tick = 1 for the single cycle the prescaler equals its maximum.
- Sync: two-FF chain on BTN; only the second stage (bs) is used downstream.
- Debounce:
  - If bs == BTN_CLEAN, the debounce counter is cleared.
  - Otherwise the counter increments on each tick. When the counter reaches DEBOUNCE_MS with bs still != BTN_CLEAN, BTN_CLEAN <= bs and the counter clears.
  - Any return of bs to BTN_CLEAN restarts the count from 0.
- PRESS: asserted in exactly the same cycle BTN_CLEAN first reads 1; never asserted for a 1->0 transition.
- Latency from a stable BTN edge to BTN_CLEAN is 2 cycles + DEBOUNCE_MS ms, with up to one tick of jitter.
- FSM states, 2-bit: IDLE=0, PENDING=1, LOCKOUT=2; code 3 is illegal and recovers to IDLE next cycle.
  - IDLE: PRESS -> PENDING. ACK is ignored. PRESS and ACK in the same cycle -> PENDING.
  - PENDING: ACK -> LOCKOUT, lockout counter = 0, deferred flag = 0. PRESS without ACK has no effect (request already held). PRESS in the same cycle as ACK is discarded.
  - LOCKOUT: the lockout counter increments on tick. PRESS sets the deferred flag; ACK is ignored. When the counter >= LOCKOUT_MS: go to PENDING if the deferred flag or PRESS is set this cycle, else IDLE; clear the counter and the flag.
- REQ: registered, equals (state == PENDING). It rises the cycle after PRESS and falls the cycle after ACK.
- WAIT_LED:
  - Set to 1 on entry to PENDING; the blink counter clears on entry.
  - Inside PENDING, on each tick the counter increments. When it reaches BLINK_HALF_MS, WAIT_LED toggles and the counter clears.
  - WAIT_LED is forced to 0 in all other states.
- Counter widths: 32-bit, compared with >= so no wrap-around is reachable.

Test Plan:
Bench uses CLK_FREQ=4000 (4 cycles/ms), DEBOUNCE_MS=20, LOCKOUT_MS=100, BLINK_HALF_MS=10.
1. Clean press: BTN 0->1 held 50 ms.
   -> BTN_CLEAN rises 80-84+2 cycles after the edge.
   -> PRESS is exactly 1 cycle wide, coincident with the BTN_CLEAN rise.
   -> REQ and WAIT_LED go to 1 the next cycle.
2. Bounce: BTN toggles every 3 ms for 30 ms, then held 1.
   -> BTN_CLEAN stays 0 until 20 ms after the last toggle.
   -> Exactly one PRESS pulse.
3. Handshake + lockout: in PENDING, pulse ACK 1 cycle.
   -> REQ=0 and WAIT_LED=0 next cycle.
   -> A new debounced press at 40 ms into lockout leaves REQ=0 until 100 ms after ACK, then REQ=1 one cycle later.
   -> With no press during lockout, REQ stays 0 and the FSM returns to IDLE.
4. Spurious ACK: ACK pulses in IDLE, and in PENDING simultaneous with a second PRESS.
   -> IDLE case: REQ remains 0.
   -> PENDING case: exactly one LOCKOUT entry, and no deferred request afterwards.
5. Blink: hold PENDING for 60 ms without ACK.
   -> WAIT_LED toggles every 10 ms (40 cycles), giving 6 edges.
   -> REQ stays steadily 1.
6. Reset mid-PENDING while BTN is held 1: RST high for 1 cycle.
   -> All outputs are 0 the next cycle.
   -> BTN_CLEAN re-rises after 20 ms, giving a fresh PRESS and REQ=1.
